// File: rtl/ts_channel_failover_ctrl_if.sv
// Signal bundle between the TS channel failover controller and its config/status/mux neighbours.
// active_valid qualifies active_ch; there is no ready, the mux consumes the select every rclk cycle.
interface ts_channel_failover_ctrl_if #(
    parameter int TIMER_W = 20,
    parameter int CNT_W   = 8
);
    logic               cfg_fallback_en;
    logic               cfg_manual_en;
    logic [1:0]         cfg_manual_ch;
    logic [7:0]         cfg_priority;
    logic [TIMER_W-1:0] cfg_reset_timer;
    logic [3:0]         sig_present;
    logic               pkt_boundary;

    logic [1:0]         active_ch;
    logic               active_valid;
    logic               switch_pulse;
    logic [CNT_W-1:0]   switch_count;
    logic               revert_busy;
    logic [1:0]         dbg_state;

    modport master (
        output cfg_fallback_en, cfg_manual_en, cfg_manual_ch, cfg_priority,
               cfg_reset_timer, sig_present, pkt_boundary,
        input  active_ch, active_valid, switch_pulse, switch_count, revert_busy, dbg_state
    );

    modport slave (
        input  cfg_fallback_en, cfg_manual_en, cfg_manual_ch, cfg_priority,
               cfg_reset_timer, sig_present, pkt_boundary,
        output active_ch, active_valid, switch_pulse, switch_count, revert_busy, dbg_state
    );
endinterface

// File: rtl/ts_channel_failover_ctrl.sv
// Selects which of four MPEG-TS input channels feeds the output mux, switching only at packet
// boundaries (or immediately when the active source disappears) with a hold-off before reverting.
module ts_channel_failover_ctrl #(
    parameter int TIMER_W = 20,
    parameter int CNT_W   = 8
) (
    input logic rclk,
    input logic rst,
    ts_channel_failover_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        NO_SIG  = 2'd0,
        ACTIVE  = 2'd1,
        REVERT  = 2'd2,
        PENDING = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [TIMER_W-1:0] rev_q, rev_d;
    logic [1:0]         rev_ch_q, rev_ch_d;

    logic [1:0] slot_ch [4];
    logic [1:0] des_ch;
    logic       des_valid;
    logic       auto_mode;
    logic       do_load;

    function automatic logic [2:0] rank_of(input logic [1:0] ch, input logic [7:0] prio);
        rank_of = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if (prio[2*k +: 2] == ch) rank_of = 3'(k);
        end
    endfunction

    // Desired target: manual override, else slot0 only, else first present slot.
    always_comb begin
        for (int k = 0; k < 4; k++) slot_ch[k] = bus.cfg_priority[2*k +: 2];
        auto_mode = bus.cfg_fallback_en && !bus.cfg_manual_en;
        des_ch    = slot_ch[0];
        des_valid = 1'b0;
        if (bus.cfg_manual_en) begin
            des_ch    = bus.cfg_manual_ch;
            des_valid = 1'b1;
        end else if (!bus.cfg_fallback_en) begin
            des_valid = bus.sig_present[slot_ch[0]];
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (bus.sig_present[slot_ch[k]]) begin
                    des_ch    = slot_ch[k];
                    des_valid = 1'b1;
                end
            end
        end
    end

    logic act_present, mismatch, revert_ok, rev_abort, rev_expired;
    assign act_present = bus.sig_present[ch_q];
    assign mismatch    = !des_valid || (des_ch != ch_q);
    assign revert_ok   = auto_mode && des_valid &&
                         (rank_of(des_ch, bus.cfg_priority) < rank_of(ch_q, bus.cfg_priority)) &&
                         (bus.cfg_reset_timer != '0);
    assign rev_abort   = !auto_mode || !des_valid || (des_ch != rev_ch_q) || (des_ch == ch_q);
    assign rev_expired = ({1'b0, rev_q} + (TIMER_W+1)'(1)) >= {1'b0, bus.cfg_reset_timer};

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q  <= NO_SIG;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rev_q    <= '0;
            rev_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rev_q    <= rev_d;
            rev_ch_q <= rev_ch_d;
        end
    end

    // A lost active source never waits for a boundary: the switch is taken on the same edge.
    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        unique case (state_q)
            NO_SIG:  do_load = des_valid;
            ACTIVE: begin
                if (!act_present)  do_load = 1'b1;
                else if (mismatch) state_d = revert_ok ? REVERT : PENDING;
            end
            REVERT: begin
                if (!act_present)     do_load = 1'b1;
                else if (rev_abort)   state_d = ACTIVE;
                else if (rev_expired) state_d = PENDING;
            end
            PENDING: begin
                if (des_valid && (des_ch == ch_q) && act_present) state_d = ACTIVE;
                else if (bus.pkt_boundary || !act_present)        do_load = 1'b1;
            end
        endcase
        if (do_load) state_d = des_valid ? ACTIVE : NO_SIG;
    end

    always_comb begin
        ch_d    = ch_q;
        valid_d = valid_q;
        if (do_load) begin
            valid_d = des_valid;
            if (des_valid) ch_d = des_ch;
        end
        pulse_d  = (ch_d != ch_q) || (valid_d != valid_q);
        cnt_d    = (pulse_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        busy_d   = (state_d == REVERT);
        rev_d    = '0;
        rev_ch_d = des_ch;
        if ((state_q == REVERT) && (state_d == REVERT)) begin
            rev_d    = (rev_q == '1) ? rev_q : rev_q + TIMER_W'(1);
            rev_ch_d = rev_ch_q;
        end
    end

    assign bus.active_ch    = ch_q;
    assign bus.active_valid = valid_q;
    assign bus.switch_pulse = pulse_q;
    assign bus.switch_count = cnt_q;
    assign bus.revert_busy  = busy_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_ts_channel_failover_ctrl.sv
// Bench for ts_channel_failover_ctrl: scripted vector table, hand-written long-revert, reset
// and saturation sequences, then random stimulus against a rule-level reference model.
module tb_ts_channel_failover_ctrl;
    localparam int TIMER_W = 20;
    localparam int CNT_W   = 8;
    localparam int SW_MAX  = (1 << CNT_W) - 1;
    localparam int AGE_MAX = (1 << TIMER_W) - 1;

    logic rclk = 1'b0;
    logic rst  = 1'b0;

    ts_channel_failover_ctrl_if #(.TIMER_W(TIMER_W), .CNT_W(CNT_W)) bus ();

    ts_channel_failover_ctrl #(.TIMER_W(TIMER_W), .CNT_W(CNT_W)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    int checks   = 0;
    int failures = 0;
    bit model_chk = 1'b0;
    logic [12:0] exp_q[$];

    typedef struct {
        logic [3:0] sp;
        logic       fb;
        logic       men;
        logic [1:0] mch;
        logic       bnd;
        logic [1:0] ch;
        logic       v;
        logic       p;
        logic [7:0] cnt;
        logic       busy;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] sp, input logic fb, input logic men,
                           input logic [1:0] mch, input logic bnd, input logic [1:0] ch,
                           input logic v, input logic p, input logic [7:0] cnt, input logic busy);
        vec_t r;
        r.sp = sp; r.fb = fb; r.men = men; r.mch = mch; r.bnd = bnd;
        r.ch = ch; r.v = v; r.p = p; r.cnt = cnt; r.busy = busy;
        tv.push_back(r);
    endtask

    // Reference model: channel choice and switching rules stated directly.
    localparam int M_IDLE = 0, M_ACT = 1, M_REV = 2, M_PEND = 3;
    int m_st, m_ch, m_rev_ch, m_age, m_sw;
    bit m_valid, m_pulse;

    function automatic int slot(input int k);
        logic [7:0] p;
        p = bus.cfg_priority;
        return int'(p[2*k +: 2]);
    endfunction

    function automatic int rank(input int ch);
        for (int k = 0; k < 4; k++) if (slot(k) == ch) return k;
        return 4;
    endfunction

    task automatic desired(output int ch, output bit valid);
        ch    = slot(0);
        valid = 1'b0;
        if (bus.cfg_manual_en) begin
            ch    = int'(bus.cfg_manual_ch);
            valid = 1'b1;
        end else if (!bus.cfg_fallback_en) begin
            valid = bus.sig_present[slot(0)];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.sig_present[slot(k)]) begin
                    ch    = slot(k);
                    valid = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_ch = 0; m_valid = 1'b0; m_pulse = 1'b0;
        m_sw = 0; m_age = 0; m_rev_ch = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int dc, old_ch, tmr;
        bit dv, auto_m, pres, load, old_v, busy;
        desired(dc, dv);
        auto_m = bus.cfg_fallback_en && !bus.cfg_manual_en;
        pres   = bus.sig_present[m_ch];
        tmr    = int'(bus.cfg_reset_timer);
        load   = 1'b0;
        old_ch = m_ch;
        old_v  = m_valid;
        case (m_st)
            M_IDLE: load = dv;
            M_ACT: begin
                if (!pres) load = 1'b1;
                else if (!dv || dc != m_ch) begin
                    if (auto_m && dv && rank(dc) < rank(m_ch) && tmr > 0) begin
                        m_st = M_REV; m_age = 0; m_rev_ch = dc;
                    end else m_st = M_PEND;
                end
            end
            M_REV: begin
                if (!pres) load = 1'b1;
                else if (!auto_m || !dv || dc != m_rev_ch || dc == m_ch) m_st = M_ACT;
                else if (m_age + 1 >= tmr) m_st = M_PEND;
                else m_age = (m_age + 1 > AGE_MAX) ? AGE_MAX : m_age + 1;
            end
            M_PEND: begin
                if (dv && dc == m_ch && pres) m_st = M_ACT;
                else if (bus.pkt_boundary || !pres) load = 1'b1;
            end
            default: ;
        endcase
        if (load) begin
            if (dv) begin
                m_ch = dc; m_valid = 1'b1; m_st = M_ACT;
            end else begin
                m_valid = 1'b0; m_st = M_IDLE;
            end
        end
        m_pulse = (m_ch != old_ch) || (m_valid != old_v);
        if (m_pulse && m_sw < SW_MAX) m_sw++;
        busy = (m_st == M_REV);
        exp_q.push_back({2'(m_ch), m_valid, m_pulse, 8'(m_sw), busy});
    endtask

    task automatic tick();
        logic [12:0] e;
        model_step();
        @(posedge rclk);
        #1;
        e = exp_q.pop_front();
        if (model_chk) begin
            check("mdl_ch",    32'(bus.active_ch),    32'(e[12:11]));
            check("mdl_valid", 32'(bus.active_valid), 32'(e[10]));
            check("mdl_pulse", 32'(bus.switch_pulse), 32'(e[9]));
            check("mdl_count", 32'(bus.switch_count), 32'(e[8:1]));
            check("mdl_busy",  32'(bus.revert_busy),  32'(e[0]));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ch"},    32'(bus.active_ch),    0);
        check({tag, "_valid"}, 32'(bus.active_valid), 0);
        check({tag, "_pulse"}, 32'(bus.switch_pulse), 0);
        check({tag, "_count"}, 32'(bus.switch_count), 0);
        check({tag, "_busy"},  32'(bus.revert_busy),  0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        check_zero(tag);
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int busy_cycles, hold_bad, b;
        bus.cfg_fallback_en = 1'b1;
        bus.cfg_manual_en   = 1'b0;
        bus.cfg_manual_ch   = 2'd0;
        bus.cfg_priority    = 8'b11_01_00_10;
        bus.cfg_reset_timer = TIMER_W'(3);
        bus.sig_present     = 4'b0000;
        bus.pkt_boundary    = 1'b0;

        //       sp      fb men mch bnd | ch v p cnt busy
        add_vec(4'b0000, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  2, 1, 1, 1, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  2, 1, 0, 1, 0);
        add_vec(4'b1011, 1, 0, 0, 0,  0, 1, 1, 2, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 2, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 2, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 2, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 2, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 2, 0);
        add_vec(4'b1111, 1, 0, 0, 1,  2, 1, 1, 3, 0);
        add_vec(4'b1011, 1, 0, 0, 0,  0, 1, 1, 4, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        add_vec(4'b1011, 1, 0, 0, 0,  0, 1, 0, 4, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  0, 1, 0, 4, 0);
        add_vec(4'b1111, 1, 0, 0, 1,  2, 1, 1, 5, 0);
        add_vec(4'b1111, 1, 1, 3, 0,  2, 1, 0, 5, 0);
        add_vec(4'b1111, 1, 1, 3, 0,  2, 1, 0, 5, 0);
        add_vec(4'b1111, 1, 1, 3, 1,  3, 1, 1, 6, 0);
        add_vec(4'b1111, 1, 1, 0, 0,  3, 1, 0, 6, 0);
        add_vec(4'b1111, 1, 1, 3, 0,  3, 1, 0, 6, 0);
        add_vec(4'b1111, 1, 1, 0, 1,  3, 1, 0, 6, 0);
        add_vec(4'b1111, 1, 1, 3, 0,  3, 1, 0, 6, 0);
        add_vec(4'b1111, 1, 0, 0, 0,  3, 1, 0, 6, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  3, 1, 0, 6, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  3, 1, 0, 6, 1);
        add_vec(4'b1111, 1, 0, 0, 0,  3, 1, 0, 6, 0);
        add_vec(4'b1111, 1, 0, 0, 1,  2, 1, 1, 7, 0);
        add_vec(4'b1111, 0, 0, 0, 0,  2, 1, 0, 7, 0);
        add_vec(4'b1011, 0, 0, 0, 0,  2, 0, 1, 8, 0);
        add_vec(4'b1011, 0, 0, 0, 0,  2, 0, 0, 8, 0);
        add_vec(4'b1111, 0, 0, 0, 0,  2, 1, 1, 9, 0);
        add_vec(4'b1111, 0, 0, 0, 0,  2, 1, 0, 9, 0);

        apply_reset("rst0");

        foreach (tv[i]) begin
            bus.sig_present     = tv[i].sp;
            bus.cfg_fallback_en = tv[i].fb;
            bus.cfg_manual_en   = tv[i].men;
            bus.cfg_manual_ch   = tv[i].mch;
            bus.pkt_boundary    = tv[i].bnd;
            tick();
            check($sformatf("tbl%0d_ch", i),    32'(bus.active_ch),    32'(tv[i].ch));
            check($sformatf("tbl%0d_valid", i), 32'(bus.active_valid), 32'(tv[i].v));
            check($sformatf("tbl%0d_pulse", i), 32'(bus.switch_pulse), 32'(tv[i].p));
            check($sformatf("tbl%0d_count", i), 32'(bus.switch_count), 32'(tv[i].cnt));
            check($sformatf("tbl%0d_busy", i),  32'(bus.revert_busy),  32'(tv[i].busy));
        end
        bus.pkt_boundary = 1'b0;

        // Long hold-off: 75000 cycles of revert_busy, then wait for a boundary.
        bus.cfg_fallback_en = 1'b1;
        bus.cfg_reset_timer = TIMER_W'(75000);
        tick();
        bus.sig_present = 4'b1011;
        tick();
        check("long_drop_ch", 32'(bus.active_ch), 0);
        bus.sig_present = 4'b1111;
        busy_cycles = 0;
        hold_bad    = 0;
        for (int i = 0; i < 80000; i++) begin
            tick();
            if (bus.active_ch !== 2'd0) hold_bad++;
            if (bus.revert_busy) busy_cycles++;
            else if (busy_cycles > 0) break;
        end
        check("long_busy_len", 32'(busy_cycles), 75000);
        repeat (3) tick();
        check("long_hold_ch", 32'(hold_bad), 0);
        check("long_wait_ch", 32'(bus.active_ch), 0);
        bus.pkt_boundary = 1'b1;
        tick();
        bus.pkt_boundary = 1'b0;
        check("long_revert_ch", 32'(bus.active_ch), 2);
        check("long_revert_pulse", 32'(bus.switch_pulse), 1);

        // Asynchronous reset while a manual switch is pending.
        bus.cfg_manual_en = 1'b1;
        bus.cfg_manual_ch = 2'd3;
        tick();
        check("pend_ch", 32'(bus.active_ch), 2);
        #2 rst = 1'b1;
        #1;
        check_zero("async");
        #2 rst = 1'b0;
        model_reset();
        bus.cfg_manual_en = 1'b0;
        tick();
        check("post_rst_ch", 32'(bus.active_ch), 2);
        check("post_rst_valid", 32'(bus.active_valid), 1);
        check("post_rst_count", 32'(bus.switch_count), 1);

        // Saturation: toggling slot0 presence with fallback off switches every cycle.
        bus.cfg_fallback_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.sig_present = (i % 2 == 0) ? 4'b1011 : 4'b1111;
            tick();
            if (i == 100) check("sat_mid_count", 32'(bus.switch_count), 102);
        end
        check("sat_count", 32'(bus.switch_count), SW_MAX);
        check("sat_pulse", 32'(bus.switch_pulse), 1);
        check("sat_valid", 32'(bus.active_valid), 1);

        // Random stimulus against the reference model.
        bus.cfg_fallback_en = 1'b1;
        bus.cfg_manual_en   = 1'b0;
        bus.cfg_reset_timer = TIMER_W'(3);
        bus.sig_present     = 4'b1111;
        apply_reset("rst1");
        model_chk = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, 3);
                bus.sig_present[b] = ~bus.sig_present[b];
            end
            bus.pkt_boundary = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) bus.cfg_priority = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) bus.cfg_reset_timer = TIMER_W'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) bus.cfg_manual_en = ~bus.cfg_manual_en;
            if ($urandom_range(0, 29) == 0) bus.cfg_manual_ch = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) bus.cfg_fallback_en = ~bus.cfg_fallback_en;
            tick();
        end
        model_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
